irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/irq_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: source count, CSR offsets and the
// per-source trigger mode encoding.
package irq_ctrl_pkg;

  localparam int unsigned NUM_SRC = 6;

  // Byte offsets of the bus-visible registers; address bits [1:0] are ignored.
  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_ENABLE  = 4'h4;
  localparam logic [3:0] OFF_MODE    = 4'h8;
  localparam logic [3:0] OFF_CLAIM   = 4'hC;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  // Claim id of source index k (0 means nothing claimable).
  function automatic logic [31:0] src_id(input int unsigned k);
    return 32'(k + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, one flop pair per bit.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_D;
      r_sync <= r_meta;
    end
  end

  assign o_Q = r_sync;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronized sources latch into PENDING (edge or level), gated by
// ENABLE and INSERVICE onto o_MEI; a small CSR bus provides W1C, claim and complete.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = irq_ctrl_pkg::NUM_SRC
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic [NUM_SRC-1:0] i_SRC,
  input  logic               i_BUS_EN,
  input  logic               i_BUS_WE,
  input  logic [3:0]         i_BUS_ADDR,
  input  logic [31:0]        i_BUS_WDATA,
  output logic [31:0]        o_BUS_RDATA,
  output logic               o_BUS_ACK,
  output logic [NUM_SRC-1:0] o_MEI
);

  logic [NUM_SRC-1:0] w_s;

  logic [NUM_SRC-1:0] r_src_prev;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_mode;
  logic [NUM_SRC-1:0] r_inservice;
  logic [31:0]        r_rdata;
  logic               r_ack;

  logic [3:0]         w_off;
  logic               w_rd;
  logic               w_wr;
  logic               w_unused_addr;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_claim_vec;
  logic [31:0]        w_claim_id;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_claim_clr;
  logic [NUM_SRC-1:0] w_cmp_vec;
  logic [NUM_SRC-1:0] w_pending_d;
  logic [NUM_SRC-1:0] w_enable_d;
  logic [NUM_SRC-1:0] w_mode_d;
  logic [NUM_SRC-1:0] w_inservice_d;
  logic [31:0]        w_rdata_d;

  sync_2ff #(
    .WIDTH (NUM_SRC)
  ) u_sync (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .i_D   (i_SRC),
    .o_Q   (w_s)
  );

  assign w_off         = {i_BUS_ADDR[3:2], 2'b00};
  assign w_unused_addr = ^i_BUS_ADDR[1:0];
  assign w_rd          = i_BUS_EN & ~i_BUS_WE;
  assign w_wr          = i_BUS_EN & i_BUS_WE;
  assign w_active      = r_pending & r_enable & ~r_inservice;

  // Pending set sources: rising edge of s in edge mode, s high while idle in level mode.
  always_comb begin
    w_set = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (r_mode[k] == MODE_EDGE) begin
        w_set[k] = w_s[k] & ~r_src_prev[k];
      end else begin
        w_set[k] = w_s[k] & ~r_inservice[k];
      end
    end
  end

  // Lowest-index claimable source wins.
  always_comb begin
    w_claim_vec = '0;
    w_claim_id  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (w_active[k] && (w_claim_id == '0)) begin
        w_claim_vec[k] = 1'b1;
        w_claim_id     = src_id(k);
      end
    end
  end

  always_comb begin
    w_cmp_vec = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_cmp_vec[k] = (i_BUS_WDATA == src_id(k)) & r_inservice[k];
    end
  end

  always_comb begin
    w_w1c       = '0;
    w_claim_clr = '0;
    w_enable_d  = r_enable;
    w_mode_d    = r_mode;
    w_rdata_d   = '0;
    if (w_wr) begin
      case (w_off)
        OFF_PENDING: w_w1c      = i_BUS_WDATA[NUM_SRC-1:0];
        OFF_ENABLE:  w_enable_d = i_BUS_WDATA[NUM_SRC-1:0];
        OFF_MODE:    w_mode_d   = i_BUS_WDATA[NUM_SRC-1:0];
        default:     ;
      endcase
    end
    if (w_rd) begin
      case (w_off)
        OFF_PENDING: w_rdata_d = 32'(r_pending);
        OFF_ENABLE:  w_rdata_d = 32'(r_enable);
        OFF_MODE:    w_rdata_d = 32'(r_mode);
        OFF_CLAIM: begin
          w_rdata_d   = w_claim_id;
          w_claim_clr = w_claim_vec;
        end
        default:     ;
      endcase
    end
  end

  // A same-cycle set beats any clear of the same bit.
  assign w_pending_d   = (r_pending & ~(w_w1c | w_claim_clr)) | w_set;
  assign w_inservice_d = (w_wr && (w_off == OFF_CLAIM)) ? (r_inservice & ~w_cmp_vec)
                                                        : (r_inservice | w_claim_clr);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_src_prev  <= '0;
      r_pending   <= '0;
      r_enable    <= '0;
      r_mode      <= '0;
      r_inservice <= '0;
      r_rdata     <= '0;
      r_ack       <= 1'b0;
    end else begin
      r_src_prev  <= w_s;
      r_pending   <= w_pending_d;
      r_enable    <= w_enable_d;
      r_mode      <= w_mode_d;
      r_inservice <= w_inservice_d;
      r_rdata     <= w_rdata_d;
      r_ack       <= i_BUS_EN;
    end
  end

  assign o_BUS_RDATA = r_rdata;
  assign o_BUS_ACK   = r_ack;
  assign o_MEI       = w_active;

  a_claim_onehot: assert property (@(posedge i_CLK) $onehot0(w_claim_vec));
  a_mei_masked:   assert property (@(posedge i_CLK) (o_MEI & r_inservice) == '0);

endmodule
